// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame, ACK check.
// Shares the open-drain ps2_clk/ps2_data pins with the keyboard receiver.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned FRM_W = 10;
    localparam int unsigned BIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         clk_sync, data_sync;
    logic [FRM_W-1:0]   shreg, shreg_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [INH_W-1:0]   inh_cnt, inh_cnt_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic               ack_seen, ack_seen_nxt;
    logic               clk_oe_nxt, data_oe_nxt, done_nxt, ack_ok_nxt, error_nxt;
    logic               busy_nxt, tx_ready_nxt;
    logic               fall, lines_high, inh_done, timeout;

    assign fall       = clk_sync[2] & ~clk_sync[1];
    assign lines_high = clk_sync[2] & data_sync[2];
    assign inh_done   = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
    assign timeout    = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Line synchronisers; reset to idle-high so no edge is seen out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 3'b111;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (tx_valid) state_nxt = S_INHIBIT;
            S_INHIBIT: if (inh_done) state_nxt = S_SEND;
            S_SEND: begin
                if (timeout)                           state_nxt = S_IDLE;
                else if (fall && bit_cnt == BIT_W'(9)) state_nxt = S_ACK;
            end
            S_ACK: begin
                if (timeout)   state_nxt = S_IDLE;
                else if (fall) state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (timeout || lines_high) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and the datapath
    always_comb begin
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        inh_cnt_nxt  = inh_cnt;
        to_cnt_nxt   = to_cnt;
        ack_seen_nxt = ack_seen;
        clk_oe_nxt   = ps2_clk_oe;
        data_oe_nxt  = ps2_data_oe;
        done_nxt     = 1'b0;
        ack_ok_nxt   = ack_ok;
        error_nxt    = error;
        case (state)
            S_IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                if (tx_valid) begin
                    shreg_nxt   = {1'b1, ~^tx_data, tx_data};
                    inh_cnt_nxt = '0;
                    ack_ok_nxt  = 1'b0;
                    error_nxt   = 1'b0;
                    clk_oe_nxt  = 1'b1;
                end
            end
            S_INHIBIT: begin
                if (inh_done) begin
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b1;
                    to_cnt_nxt  = '0;
                    bit_cnt_nxt = '0;
                end else begin
                    inh_cnt_nxt = inh_cnt + INH_W'(1);
                end
            end
            S_SEND, S_ACK, S_RELEASE: begin
                to_cnt_nxt = to_cnt + TO_W'(1);
                if (timeout) begin
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b0;
                    done_nxt    = 1'b1;
                    ack_ok_nxt  = 1'b0;
                    error_nxt   = 1'b1;
                end else if (state == S_SEND) begin
                    if (fall) begin
                        data_oe_nxt = ~shreg[0];
                        shreg_nxt   = {1'b0, shreg[FRM_W-1:1]};
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end else if (state == S_ACK) begin
                    if (fall) ack_seen_nxt = ~data_sync[1];
                end else if (lines_high) begin
                    done_nxt   = 1'b1;
                    ack_ok_nxt = ack_seen;
                    error_nxt  = ~ack_seen;
                end
            end
            default: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
            end
        endcase
        busy_nxt     = (state_nxt != S_IDLE);
        tx_ready_nxt = (state_nxt == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            ack_seen    <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
        end else begin
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            inh_cnt     <= inh_cnt_nxt;
            to_cnt      <= to_cnt_nxt;
            ack_seen    <= ack_seen_nxt;
            ps2_clk_oe  <= clk_oe_nxt;
            ps2_data_oe <= data_oe_nxt;
            done        <= done_nxt;
            ack_ok      <= ack_ok_nxt;
            error       <= error_nxt;
            busy        <= busy_nxt;
            tx_ready    <= tx_ready_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on open-drain lines, expected
// results queued by the stimulus and checked by a done-pulse monitor.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 8;
    localparam int unsigned TO   = 4000;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, error;
    logic       ps2_clk_w, ps2_data_w;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_w  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_w = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ps2_clk(ps2_clk_w),
        .ps2_data(ps2_data_w),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .done(done),
        .ack_ok(ack_ok),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic       ack_ok;
        logic       error;
        logic       chk_frame;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          send_cyc = 0;
    int          done_cyc = 0;
    int          dev_mode = 0;   // 0 ack, 1 no ack, 2 silent
    int          dev_edges = 0;
    logic        dev_busy = 1'b0;
    logic [10:0] dev_bits = '1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Device: waits for request, clocks 11 times, samples on rising edges
    initial begin : device
        forever begin
            @(negedge clk);
            if (ps2_clk_w && !ps2_data_w) begin
                dev_busy    = 1'b1;
                dev_bits    = '1;
                dev_bits[0] = ps2_data_w;
                if (dev_mode == 2) begin
                    while (!ps2_data_w) @(negedge clk);
                end else begin
                    repeat (10) @(negedge clk);
                    for (int k = 1; k <= 11; k++) begin
                        dev_clk_low = 1'b1;
                        dev_edges   = k;
                        repeat (HALF) @(negedge clk);
                        dev_clk_low = 1'b0;
                        if (k <= 10) dev_bits[k] = ps2_data_w;
                        if (k == 10 && dev_mode == 0) dev_data_low = 1'b1;
                        if (k == 11) dev_data_low = 1'b0;
                        repeat (HALF) @(negedge clk);
                    end
                end
                dev_edges = 0;
                dev_busy  = 1'b0;
            end
        end
    end

    // Monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_cnt++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_ok", ack_ok, e.ack_ok);
                chk("error", error, e.error);
                chk("busy_at_done", busy, 0);
                chk("ready_at_done", tx_ready, 1);
                chk("clk_oe_at_done", ps2_clk_oe, 0);
                chk("data_oe_at_done", ps2_data_oe, 0);
                if (e.chk_frame) begin
                    chk("dev_start", dev_bits[0], 0);
                    chk("dev_data", dev_bits[8:1], e.data);
                    chk("dev_parity", dev_bits[9], e.parity);
                    chk("dev_stop", dev_bits[10], 1);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic start_tx(input logic [7:0] d, input logic par, input logic ak,
                            input logic er, input logic cf, input logic push);
        exp_t e;
        int   n;
        int   guard;
        e.data = d; e.parity = par; e.ack_ok = ak; e.error = er; e.chk_frame = cf;
        if (push) exp_q.push_back(e);
        guard = 0;
        while (!tx_ready && guard < 1000) begin @(negedge clk); guard++; end
        chk("ready_before_tx", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
        chk("ready_after_accept", tx_ready, 0);
        n = 0;
        while (ps2_clk_oe && n < 100) begin n++; @(negedge clk); end
        chk("inhibit_len", n, INH);
        chk("start_bit_oe", ps2_data_oe, 1);
        send_cyc = cyc;
    endtask

    task automatic wait_done(input string name);
        int base;
        int guard;
        base  = done_cnt;
        guard = 0;
        while (done_cnt == base && guard < 20000) begin @(negedge clk); guard++; end
        chk({name, "_done_seen"}, 32'(done_cnt != base), 1);
    endtask

    task automatic wait_dev_idle();
        int guard;
        guard = 0;
        while (dev_busy && guard < 20000) begin @(negedge clk); guard++; end
        chk("dev_idle", dev_busy, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin : stimulus
        int base;
        int guard;
        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {ack_ok, error}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xED: popcount 6 -> parity 1
        dev_mode = 0;
        start_tx(8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done("ed");
        @(negedge clk);
        chk("ack_ok_hold", ack_ok, 1);
        wait_dev_idle();

        // 0xF4: popcount 5 -> parity 0
        start_tx(8'hF4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done("f4");
        wait_dev_idle();

        // Missing ACK on 0x00 (parity 1)
        dev_mode = 1;
        start_tx(8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_done("noack");
        wait_dev_idle();

        // Device never clocks: timeout measured from SEND entry
        dev_mode = 2;
        start_tx(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_done("timeout");
        chk("timeout_cycles", 32'(done_cyc - send_cyc), TO);
        wait_dev_idle();

        // Reset at falling edge 5 of a 0x55 frame
        dev_mode = 0;
        start_tx(8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        guard = 0;
        while (dev_edges != 5 && guard < 5000) begin @(negedge clk); guard++; end
        chk("reached_edge5", dev_edges, 5);
        base = done_cnt;
        rst  = 1'b1;
        @(negedge clk);
        chk("midrst_clk_oe", ps2_clk_oe, 0);
        chk("midrst_data_oe", ps2_data_oe, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", tx_ready, 1);
        rst = 1'b0;
        wait_dev_idle();
        chk("no_done_after_rst", done_cnt, base);
        start_tx(8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done("55");
        wait_dev_idle();

        // tx_valid with 0xAA while 0xED is in flight must be ignored
        start_tx(8'hED, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (60) @(negedge clk);
        chk("ready_while_busy", tx_ready, 0);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        wait_done("ed_inject");
        wait_dev_idle();
        repeat (600) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        chk("done_count", done_cnt, 6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
